// File: rtl/cpu_seq_ctrl.sv
// Multicycle fetch/decode/execute sequencer for the 16-bit cpu, with a mul/div start/done handshake guarded by a timeout.
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter; otherwise retired_cnt is tied to zero.
module cpu_seq_ctrl #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] PC_RESET   = '0,
  parameter int                MD_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              en_ram_out,
  input  logic [15:0]       ins,
  output logic              en_ram_in,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        alu_op,
  output logic [1:0]        rd_sel,
  output logic [1:0]        rs_sel,
  output logic              imm_sel,
  output logic [15:0]       imm,
  output logic              reg_we,
  output logic              flag_we,
  output logic              md_start,
  input  logic              md_done,
  output logic              busy,
  output logic              illegal,
  output logic [15:0]       retired_cnt
);

  localparam int                CNT_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_INS, DECODE, EXEC, MD_WAIT, WB
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic              supp_q, supp_d;
  logic [3:0]        op;
  logic              unused_ir_bits;

  function automatic logic op_legal(input logic [3:0] o);
    case (o)
      4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
      4'h9, 4'hA, 4'hB, 4'hC, 4'hD: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] o);
    case (o)
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
      4'h9, 4'hA, 4'hC, 4'hD: op_writes_reg = 1'b1;
      default:                op_writes_reg = 1'b0;
    endcase
  endfunction

  function automatic logic op_writes_flag(input logic [3:0] o);
    case (o)
      4'h4, 4'h5, 4'h6, 4'h7, 4'hB: op_writes_flag = 1'b1;
      default:                      op_writes_flag = 1'b0;
    endcase
  endfunction

  assign op             = ir_q[15:12];
  assign alu_op         = ir_q[15:12];
  assign rd_sel         = ir_q[9:8];
  assign rs_sel         = ir_q[1:0];
  assign imm_sel        = ir_q[7];
  assign imm            = {9'd0, ir_q[6:0]};
  assign addr           = addr_q;
  assign busy           = (state_q != IDLE);
  assign unused_ir_bits = ^ir_q[11:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= PC_RESET;
      ir_q     <= '0;
      md_cnt_q <= '0;
      supp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      md_cnt_q <= md_cnt_d;
      supp_q   <= supp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    md_cnt_d  = md_cnt_q;
    supp_d    = supp_q;
    en_ram_in = 1'b0;
    md_start  = 1'b0;
    reg_we    = 1'b0;
    flag_we   = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      IDLE: if (en_in) state_d = FETCH;
      FETCH: begin
        en_ram_in = 1'b1;
        state_d   = WAIT_INS;
      end
      WAIT_INS: if (en_ram_out) begin
        ir_d    = ins;
        state_d = DECODE;
      end
      DECODE: begin
        // A bad opcode still passes through WB so the PC advances past it.
        if (op_legal(op)) begin
          supp_d  = 1'b0;
          state_d = EXEC;
        end else begin
          illegal = 1'b1;
          supp_d  = 1'b1;
          state_d = WB;
        end
      end
      EXEC: begin
        if (op == 4'h6 || op == 4'h7) begin
          md_start = 1'b1;
          md_cnt_d = '0;
          state_d  = MD_WAIT;
        end else begin
          state_d = WB;
        end
      end
      MD_WAIT: begin
        md_cnt_d = md_cnt_q + 1'b1;
        if (md_done) begin
          state_d = WB;
        end else if (md_cnt_q == CNT_LAST) begin
          illegal = 1'b1;
          supp_d  = 1'b1;
          state_d = WB;
        end
      end
      WB: begin
        reg_we  = !supp_q && op_writes_reg(op);
        flag_we = !supp_q && op_writes_flag(op);
        addr_d  = addr_q + 1'b1;
        state_d = en_in ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (state_q == WB && !supp_q) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = 16'd0;
`endif

endmodule
